pe_seq_ctrl: RTL and testbench

- Sequencer for a single PE in the conv datapath. Accepts a job config and sequences the PE through the job:
  - weight load (weight-stationary mode only);
  - start;
  - K-tap MAC feed;
  - end-of-accumulation (output-stationary mode only);
  - psum capture.
- Moves filter/ifmap values from valid/ready streams into the PE's read-strobe interface.
- Returns each psum on a valid/ready result port.
- Sits between the buffer/DMA side and one PE.

---
 rtl/pe_seq_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_pe_seq_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_seq_ctrl.sv
// pe_seq_ctrl: sequences one conv PE through weight load, MAC feed and psum return.
// Optional psum-wait watchdog with sticky err_o: define PE_SEQ_CTRL_WATCHDOG_EN.
module pe_seq_ctrl #(
  parameter int DATA_W   = 8,
  parameter int PSUM_W   = 10,
  parameter int KERNEL_W = 3,
  parameter int NOUT_W   = 4
`ifdef PE_SEQ_CTRL_WATCHDOG_EN
  ,
  parameter int WDOG_CYC = 64
`endif
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cfg_valid_i,
  output logic              cfg_ready_o,
  input  logic              cfg_mode_i,
  input  logic [NOUT_W-1:0] cfg_num_out_i,
  input  logic              filt_valid_i,
  output logic              filt_ready_o,
  input  logic [DATA_W-1:0] filt_data_i,
  input  logic              ifm_valid_i,
  output logic              ifm_ready_o,
  input  logic [DATA_W-1:0] ifm_data_i,
  output logic [DATA_W-1:0] pe_filter_o,
  output logic [DATA_W-1:0] pe_ifmap_o,
  output logic              pe_read_filter_o,
  output logic              pe_read_ifmap_o,
  output logic              pe_start_o,
  output logic              pe_mode_o,
  output logic              pe_end_os_o,
  input  logic [PSUM_W-1:0] pe_psum_i,
  input  logic              pe_psum_valid_i,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic [PSUM_W-1:0] res_data_o,
  output logic              res_last_o,
  output logic              done_o,
  output logic              busy_o
`ifdef PE_SEQ_CTRL_WATCHDOG_EN
  ,
  output logic              err_o
`endif
);

  localparam int TAP_W = (KERNEL_W > 1) ? $clog2(KERNEL_W) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_W, S_START, S_MAC, S_END_OS, S_WAIT, S_OUT
  } state_t;

  state_t              state, state_nxt;
  logic                mode_q;
  logic [NOUT_W-1:0]   num_out_q;
  logic [NOUT_W-1:0]   out_cnt;
  logic [TAP_W-1:0]    tap_cnt;
  logic [PSUM_W-1:0]   res_data_q;
  logic                done_q;
  logic                load_hs, mac_hs, res_hs, last_tap, last_out, wdog_expire;

`ifdef PE_SEQ_CTRL_WATCHDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYC + 1);
  logic [WDOG_W-1:0]   wdog_cnt;
  logic                err_q;
  assign wdog_expire = (state == S_WAIT) && !pe_psum_valid_i &&
                       (wdog_cnt == WDOG_W'(WDOG_CYC - 1));
`else
  assign wdog_expire = 1'b0;
`endif

  // OS mode only advances when both operands are present, so they are consumed as a pair.
  assign load_hs  = (state == S_LOAD_W) && filt_valid_i;
  assign mac_hs   = (state == S_MAC) && ifm_valid_i && (!mode_q || filt_valid_i);
  assign res_hs   = (state == S_OUT) && res_ready_i;
  assign last_tap = (tap_cnt == TAP_W'(KERNEL_W - 1));
  assign last_out = (out_cnt == num_out_q - NOUT_W'(1));

  // NOTE: sequential state uses <= so every register samples pre-edge values
  // regardless of the order in which processes evaluate.
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (cfg_valid_i && cfg_num_out_i != '0)
                  state_nxt = cfg_mode_i ? S_START : S_LOAD_W;
      S_LOAD_W: if (load_hs && last_tap) state_nxt = S_START;
      S_START:  state_nxt = S_MAC;
      S_MAC:    if (mac_hs && last_tap) state_nxt = mode_q ? S_END_OS : S_WAIT;
      S_END_OS: state_nxt = S_WAIT;
      S_WAIT:   if (pe_psum_valid_i || wdog_expire) state_nxt = S_OUT;
      S_OUT:    if (res_hs) state_nxt = last_out ? S_IDLE : S_START;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // NOTE: every output gets a default first, so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    cfg_ready_o  = 1'b0;
    filt_ready_o = 1'b0;
    ifm_ready_o  = 1'b0;
    pe_start_o   = 1'b0;
    pe_end_os_o  = 1'b0;
    pe_mode_o    = 1'b0;
    res_valid_o  = 1'b0;
    res_last_o   = 1'b0;
    res_data_o   = '0;
    done_o       = 1'b0;
    busy_o       = 1'b0;
`ifdef PE_SEQ_CTRL_WATCHDOG_EN
    err_o        = 1'b0;
`endif
    if (rst_i) begin
      cfg_ready_o = 1'b1;
    end else begin
      busy_o     = (state != S_IDLE);
      pe_mode_o  = mode_q;
      res_data_o = res_data_q;
      done_o     = done_q;
`ifdef PE_SEQ_CTRL_WATCHDOG_EN
      err_o      = err_q;
`endif
      case (state)
        S_IDLE:   cfg_ready_o = 1'b1;
        S_LOAD_W: filt_ready_o = 1'b1;
        S_START:  pe_start_o = 1'b1;
        S_MAC: begin
          filt_ready_o = mode_q && filt_valid_i && ifm_valid_i;
          ifm_ready_o  = mode_q ? (filt_valid_i && ifm_valid_i) : 1'b1;
        end
        S_END_OS: pe_end_os_o = 1'b1;
        S_OUT: begin
          res_valid_o = 1'b1;
          res_last_o  = last_out;
        end
        default: ;
      endcase
    end
  end

  assign pe_filter_o      = filt_data_i;
  assign pe_ifmap_o       = ifm_data_i;
  assign pe_read_filter_o = filt_valid_i & filt_ready_o;
  assign pe_read_ifmap_o  = ifm_valid_i & ifm_ready_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mode_q     <= 1'b0;
      num_out_q  <= '0;
      out_cnt    <= '0;
      tap_cnt    <= '0;
      res_data_q <= '0;
      done_q     <= 1'b0;
`ifdef PE_SEQ_CTRL_WATCHDOG_EN
      wdog_cnt   <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      done_q <= ((state == S_IDLE) && cfg_valid_i && cfg_num_out_i == '0) ||
                (res_hs && last_out);
      if (state == S_IDLE && cfg_valid_i) begin
        mode_q    <= cfg_mode_i;
        num_out_q <= cfg_num_out_i;
        out_cnt   <= '0;
        tap_cnt   <= '0;
      end
      if (load_hs || mac_hs) tap_cnt <= last_tap ? '0 : tap_cnt + TAP_W'(1);
      if (state == S_WAIT && pe_psum_valid_i) res_data_q <= pe_psum_i;
      if (res_hs && !last_out) out_cnt <= out_cnt + NOUT_W'(1);
`ifdef PE_SEQ_CTRL_WATCHDOG_EN
      wdog_cnt <= (state == S_WAIT) ? wdog_cnt + WDOG_W'(1) : '0;
      if (wdog_expire) begin
        err_q      <= 1'b1;
        res_data_q <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// Bench for pe_seq_ctrl: directed and random jobs against a dot-product reference,
// with a simple latency-L PE model driving the psum port.
module tb_pe_seq_ctrl;

  localparam int DATA_W = 8;
  localparam int PSUM_W = 10;
  localparam int K      = 3;
  localparam int NOUT_W = 4;
  localparam int WDOG   = 8;
  localparam int BUDGET = 3000;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              cfg_valid_i, cfg_ready_o, cfg_mode_i;
  logic [NOUT_W-1:0] cfg_num_out_i;
  logic              filt_valid_i, filt_ready_o;
  logic [DATA_W-1:0] filt_data_i;
  logic              ifm_valid_i, ifm_ready_o;
  logic [DATA_W-1:0] ifm_data_i;
  logic [DATA_W-1:0] pe_filter_o, pe_ifmap_o;
  logic              pe_read_filter_o, pe_read_ifmap_o;
  logic              pe_start_o, pe_mode_o, pe_end_os_o;
  logic [PSUM_W-1:0] pe_psum_i;
  logic              pe_psum_valid_i;
  logic              res_valid_o, res_ready_i, res_last_o;
  logic [PSUM_W-1:0] res_data_o;
  logic              done_o, busy_o;
`ifdef PE_SEQ_CTRL_WATCHDOG_EN
  logic              err_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  pe_seq_ctrl #(
    .DATA_W(DATA_W), .PSUM_W(PSUM_W), .KERNEL_W(K), .NOUT_W(NOUT_W)
`ifdef PE_SEQ_CTRL_WATCHDOG_EN
    , .WDOG_CYC(WDOG)
`endif
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
    .cfg_mode_i(cfg_mode_i), .cfg_num_out_i(cfg_num_out_i),
    .filt_valid_i(filt_valid_i), .filt_ready_o(filt_ready_o), .filt_data_i(filt_data_i),
    .ifm_valid_i(ifm_valid_i), .ifm_ready_o(ifm_ready_o), .ifm_data_i(ifm_data_i),
    .pe_filter_o(pe_filter_o), .pe_ifmap_o(pe_ifmap_o),
    .pe_read_filter_o(pe_read_filter_o), .pe_read_ifmap_o(pe_read_ifmap_o),
    .pe_start_o(pe_start_o), .pe_mode_o(pe_mode_o), .pe_end_os_o(pe_end_os_o),
    .pe_psum_i(pe_psum_i), .pe_psum_valid_i(pe_psum_valid_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .res_data_o(res_data_o), .res_last_o(res_last_o),
    .done_o(done_o), .busy_o(busy_o)
`ifdef PE_SEQ_CTRL_WATCHDOG_EN
    , .err_o(err_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  // Everything except cfg_ready_o and the data pass-throughs must be 0 in and after reset.
  logic [20:0] other_outs;
  assign other_outs = {filt_ready_o, ifm_ready_o, pe_read_filter_o, pe_read_ifmap_o,
                       pe_start_o, pe_mode_o, pe_end_os_o, res_valid_o, res_data_o,
                       res_last_o, done_o, busy_o};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               tag, got, got, exp, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    cfg_valid_i = 1'b0; cfg_mode_i = 1'b0; cfg_num_out_i = '0;
    filt_valid_i = 1'b0; filt_data_i = '0;
    ifm_valid_i = 1'b0; ifm_data_i = '0;
    pe_psum_valid_i = 1'b0; pe_psum_i = '0;
    res_ready_i = 1'b0;
  endtask

  // One complete job. lat = PE psum latency after the last tap (WS) or the end pulse (OS);
  // lat = 0 means the PE never answers. gap = cycles from job start with ifmap held invalid.
  task automatic run_job(input bit mode, input int n, input int lat, input bit rnd,
                         input bit seq, input int gap, input int stall,
                         input bit chk_lat, input bit err_exp);
    logic [DATA_W-1:0] fq[$], iq[$], fa[$], ia[$];
    logic [PSUM_W-1:0] exp_q[$];
    logic [DATA_W-1:0] pe_w[K];
    logic [PSUM_W-1:0] pe_acc = '0, prev_data = '0;
    int pe_wi = 0, pe_tap = 0, pe_timer = 0;
    int cyc = 0, c0 = -1, last_hs = -1, done_exp = -1, n_done = 0, k = 0, tail = -1;
    int n_fr = 0, n_ir = 0, n_st = 0, n_eos = 0, stall_cnt = 0;
    int bad_busy = 0, bad_cfg = 0, bad_idle = 0, bad_joint = 0, bad_out = 0;
    int bad_stab = 0, bad_gap = 0;
    bit cfg_pend = 1'b1, prev_stall = 1'b0, fhs, ihs;
    int n_filt, lat_eff;

    for (int i = 0; i < K; i++) pe_w[i] = '0;
    n_filt = (n == 0) ? 0 : (mode ? n * K : K);
    for (int i = 0; i < n_filt; i++) fa.push_back(seq ? DATA_W'(i + 1) : DATA_W'($urandom));
    for (int i = 0; i < n * K; i++) ia.push_back(seq ? DATA_W'(i + 4) : DATA_W'($urandom));
    fq = fa; iq = ia;
    for (int o = 0; o < n; o++) begin
      int s = 0;
      for (int j = 0; j < K; j++)
        s += int'(mode ? fa[o * K + j] : fa[j]) * int'(ia[o * K + j]);
      exp_q.push_back((lat == 0) ? '0 : PSUM_W'(s));
    end

    while (tail != 0 && cyc < BUDGET) begin
      @(negedge clk_i);
      cfg_valid_i   = cfg_pend || (rnd && n > 0 && c0 >= 0 && last_hs < 0 && $urandom_range(1) == 1);
      cfg_mode_i    = mode;
      cfg_num_out_i = NOUT_W'(n);
      filt_valid_i  = fq.size() > 0 && (!rnd || $urandom_range(3) != 0);
      filt_data_i   = fq.size() > 0 ? fq[0] : DATA_W'($urandom);
      ifm_valid_i   = iq.size() > 0 && cyc >= gap && (!rnd || $urandom_range(3) != 0);
      ifm_data_i    = iq.size() > 0 ? iq[0] : DATA_W'($urandom);
      pe_psum_valid_i = 1'b0;
      if (pe_timer > 0) begin
        pe_timer--;
        if (pe_timer == 0) pe_psum_valid_i = 1'b1;
      end
      pe_psum_i   = pe_psum_valid_i ? pe_acc : PSUM_W'($urandom);
      res_ready_i = (stall_cnt >= stall) && (!rnd || $urandom_range(2) != 0);
      #1;
      fhs = pe_read_filter_o;
      ihs = pe_read_ifmap_o;
      if (cfg_ready_o == busy_o) bad_busy++;
      if (n == 0 && !cfg_ready_o) bad_idle++;
      if (mode && fhs != ihs) bad_joint++;
      if (res_valid_o && (ihs || pe_start_o)) bad_out++;
      if (cyc < gap && (fhs || ihs)) bad_gap++;
      if (prev_stall && (!res_valid_o || res_data_o != prev_data)) bad_stab++;
      prev_stall = res_valid_o && !res_ready_i;
      prev_data  = res_data_o;
      if (res_valid_o && !res_ready_i) stall_cnt++;
      if (cfg_valid_i && cfg_ready_o) begin
        if (cfg_pend) begin
          cfg_pend = 1'b0;
          c0 = cyc;
          if (n == 0) done_exp = cyc + 1;
        end else bad_cfg++;
      end
      // PE model
      if (pe_start_o) begin pe_acc = '0; pe_tap = 0; n_st++; end
      if (pe_end_os_o) begin n_eos++; if (lat > 0) pe_timer = lat; end
      if (fhs) begin
        n_fr++;
        void'(fq.pop_front());
        if (!mode) begin pe_w[pe_wi % K] = pe_filter_o; pe_wi++; end
      end
      if (ihs) begin
        n_ir++;
        void'(iq.pop_front());
        pe_acc = PSUM_W'(int'(pe_acc) +
                 int'(mode ? pe_filter_o : pe_w[pe_tap % K]) * int'(pe_ifmap_o));
        pe_tap++;
        if (!mode && pe_tap == K && lat > 0) pe_timer = lat;
      end
      if (res_valid_o && res_ready_i) begin
        if (k < n) begin
          check("res_data", 32'(res_data_o), 32'(exp_q[k]));
          check("res_last", 32'(res_last_o), 32'(k == n - 1));
`ifdef PE_SEQ_CTRL_WATCHDOG_EN
          check("err_o", 32'(err_o), 32'(lat == 0 || err_exp));
`endif
        end else check("extra_result", k, n);
        k++;
        stall_cnt = 0;
        if (k == n) begin last_hs = cyc; done_exp = cyc + 1; end
      end
      if (done_o) begin
        n_done++;
        check("done_time", cyc, done_exp);
        if (tail < 0) tail = 3;
      end
      if (tail > 0) tail--;
      cyc++;
    end

    check("done_pulses", n_done, 1);
    check("filt_reads", n_fr, n_filt);
    check("ifm_reads", n_ir, n * K);
    check("starts", n_st, n);
    check("end_os_pulses", n_eos, mode ? n : 0);
    check("results", k, n);
    check("busy_cfg", bad_busy + bad_cfg + bad_idle, 0);
    check("os_joint", bad_joint, 0);
    check("out_hold", bad_out + bad_stab, 0);
    check("gap_reads", bad_gap, 0);
    if (chk_lat && n > 0) begin
      lat_eff = (lat == 0) ? WDOG : lat;
      check("latency", last_hs - c0, (mode ? 0 : K) + n * (K + lat_eff + 2 + int'(mode)));
    end
    idle_inputs();
  endtask

  task automatic reset_mid_mac();
    int taps = 0, guard = 0;
    @(negedge clk_i);
    cfg_valid_i = 1'b1; cfg_mode_i = 1'b1; cfg_num_out_i = NOUT_W'(1);
    @(negedge clk_i);
    cfg_valid_i = 1'b0;
    while (taps == 0 && guard < 20) begin
      if (guard > 0) @(negedge clk_i);
      filt_valid_i = 1'b1; ifm_valid_i = 1'b1;
      filt_data_i = DATA_W'($urandom); ifm_data_i = DATA_W'($urandom);
      #1;
      if (pe_read_ifmap_o) taps++;
      guard++;
    end
    check("pre_reset_taps", taps, 1);
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    check("rst_cycle_reads", 32'({pe_read_filter_o, pe_read_ifmap_o}), 0);
    check("rst_cycle_cfg_ready", 32'(cfg_ready_o), 1);
    check("rst_cycle_outputs", 32'(other_outs), 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    idle_inputs();
    #1;
    check("post_rst_cfg_ready", 32'(cfg_ready_o), 1);
    check("post_rst_outputs", 32'(other_outs), 0);
`ifdef PE_SEQ_CTRL_WATCHDOG_EN
    check("post_rst_err", 32'(err_o), 0);
`endif
  endtask

  initial begin
    int bad_idle_psum = 0;
    rst_i = 1'b1;
    idle_inputs();
    @(negedge clk_i);
    #1;
    check("reset_cfg_ready", 32'(cfg_ready_o), 1);
    check("reset_outputs", 32'(other_outs), 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    check("after_reset_cfg_ready", 32'(cfg_ready_o), 1);
    check("after_reset_outputs", 32'(other_outs), 0);

    // A psum strobe outside WAIT must be ignored.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      pe_psum_valid_i = 1'b1; pe_psum_i = PSUM_W'($urandom);
      #1;
      if (res_valid_o || busy_o) bad_idle_psum++;
    end
    @(negedge clk_i);
    idle_inputs();
    #1;
    check("idle_psum_ignored", bad_idle_psum + int'(res_valid_o) + int'(busy_o), 0);

    run_job(1'b0, 2, 2, 1'b0, 1'b1, 0, 0, 1'b1, 1'b0);   // WS 1,2,3 x 4..9 -> 32, 50
    run_job(1'b1, 1, 2, 1'b0, 1'b0, 7, 0, 1'b0, 1'b0);   // OS with ifmap gap
    run_job(1'b0, 0, 2, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);   // empty job
    run_job(1'b0, 2, 3, 1'b0, 1'b0, 0, 10, 1'b0, 1'b0);  // result back-pressure
    reset_mid_mac();
    run_job(1'b1, 1, 1, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
    run_job(1'b1, 3, 3, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
    for (int j = 0; j < 20; j++) begin
      int n = ($urandom_range(5) == 0) ? 0 : int'($urandom_range(7, 1));
      run_job(1'($urandom_range(1)), n, int'($urandom_range(4, 1)), 1'b1, 1'b0,
              0, 0, 1'b0, 1'b0);
    end
`ifdef PE_SEQ_CTRL_WATCHDOG_EN
    run_job(1'b0, 2, 0, 1'b0, 1'b0, 0, 0, 1'b1, 1'b1);   // PE silent: watchdog fires
    run_job(1'b1, 1, 2, 1'b0, 1'b0, 0, 0, 1'b1, 1'b1);   // err_o stays set
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
